uart_rx_sequencer: RTL and testbench
====================================

// Module: uart_rx_sequencer
// PURPOSE
// UART receive controller. Detects a start bit on the serial line, times mid-bit
// sample points from an oversampling baud tick and strobes the existing shiftreg
// (latch/stream) once per data bit. After the stop bit it captures the shiftreg
// parallel output into a holding register offered via a valid/ready handshake.
// PARAMETERS
// OVERSAMPLE  16  baud_tick pulses per bit period; even, >=4
// DATA_BITS   8   data bits per frame, LSB first; must equal shiftreg MSB
// PORTS
// clk        in   1          system clock, rising edge
// reset      in   1          asynchronous, active-high reset
// baud_tick  in   1          1-clk strobe at OVERSAMPLE x baud; pulses >=2 clk apart
// rx         in   1          raw serial line, idle high, asynchronous
// par_in     in   DATA_BITS  shiftreg parallel output (shiftreg.out)
// latch      out  1          to shiftreg.latch; 0 for exactly 1 clk per data bit
// stream     out  1          to shiftreg.stream; sampled bit value
// rx_data    out  DATA_BITS  received byte, held while rx_valid=1
// rx_valid   out  1          rx_data holds an unconsumed byte
// rx_ready   in   1          consumer accepts rx_data when rx_valid & rx_ready
// frame_err  out  1          1-clk pulse: stop bit sampled low
// overrun    out  1          1-clk pulse: frame completed while rx_valid=1, no ready
// busy       out  1          state != IDLE
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, counters=0, sync flops=1, latch=1, stream=1,
//   rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. Applies mid-frame too;
//   partial frame discarded, shiftreg handled by its own reset.
// - rx passes a 2-flop synchronizer -> rx_s; all decisions use rx_s only.
// - tick_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1); counters
//   advance only on clk edges with baud_tick=1.
// - IDLE: rx_s==0 -> START, tick_cnt=0.
// - START: on tick, tick_cnt++; on the tick where tick_cnt==OVERSAMPLE/2-1:
//   rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0; rx_s==1 -> IDLE (glitch, no strobe).
// - DATA: on tick where tick_cnt==OVERSAMPLE-1 (mid-bit): stream<=rx_s, latch<=0,
//   tick_cnt=0, bit_cnt++; after the DATA_BITS-th sample -> STOP. Otherwise tick_cnt++.
// - latch returns to 1 on the following clk edge (low exactly one clk); shiftreg
//   shifts on that edge, so bit0 ends in par_in[0].
// - STOP: on tick where tick_cnt==OVERSAMPLE-1 sample rx_s, go IDLE same edge:
//   rx_s==1 & (!rx_valid | rx_ready) -> rx_data<=par_in, rx_valid<=1;
//   rx_s==1 & rx_valid & !rx_ready -> overrun pulse, rx_data unchanged, frame dropped;
//   rx_s==0 -> frame_err pulse, no load, rx_valid unaffected except by handshake.
// - Handshake: rx_valid & rx_ready at an edge clears rx_valid unless a load occurs
//   on that edge (load wins: rx_valid stays 1, new data, no overrun).
// - rx_data stable whenever rx_valid=1 and no accepted load; no combinational
//   path rx_ready->rx_valid.
// - Line held low after a frame: IDLE re-enters START; a stuck-low line gives
//   repeated frame_err, never hangs.
// - baud_tick ignored in IDLE; rx changes without ticks cannot advance counters.
// TESTING (OVERSAMPLE=16, DATA_BITS=8, shiftreg#(8) attached, tick every 4 clk)
// - Frame 0xA5, rx_ready=0 -> exactly 8 latch-low pulses, stream=1,0,1,0,0,1,0,1,
//   rx_data=0xA5, rx_valid=1 held; ready=1 one clk -> rx_valid=0 next edge.
// - rx low for 4 ticks then high -> back to IDLE, zero latch pulses, busy drops.
// - Frame 0x3C with stop bit low -> one frame_err pulse, rx_valid stays 0.
// - Frames 0x3C then 0xC3, ready=0 -> rx_data=0x3C kept, one overrun pulse.
// - Ready asserted on the exact edge 0xC3 loads after 0x3C -> rx_data=0xC3,
//   rx_valid=1, no overrun.
// - Reset asserted after 3rd data bit -> outputs at reset values before next clk;
//   following frame 0x55 received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sequencer
// Purpose  : UART receive controller. Finds the start bit on the serial line,
//            times mid-bit sample points from an oversampling baud tick and
//            strobes an external shift register once per data bit. After the
//            stop bit the shift register's parallel output is captured into a
//            holding register and offered through a valid/ready handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-high reset
//            baud_tick  - 1-clk strobe at OVERSAMPLE x baud rate
//            rx         - raw serial line, idle high, asynchronous
//            par_in     - shift register parallel output
//            latch      - shift register strobe, low for one clk per data bit
//            stream     - sampled bit value fed to the shift register
//            rx_data    - received word, held while rx_valid is high
//            rx_valid   - rx_data holds an unconsumed word
//            rx_ready   - consumer accepts rx_data when rx_valid & rx_ready
//            frame_err  - 1-clk pulse: stop bit sampled low
//            overrun    - 1-clk pulse: frame dropped, holding register full
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] par_in,
    output logic                 latch,
    output logic                 stream,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    // START waits half a bit so that every later sample lands mid-bit.
    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic                r_rx_meta;
    logic                r_rx_s;
    logic [1:0]          r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;

    logic w_tick_last;
    logic w_stop_sample;
    logic w_load;
    logic w_overrun;
    logic w_frame_err;

    // Two-flop synchronizer; reset to the idle line level so that reset
    // release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick_last   = (r_tick_cnt == c_TICK_LAST);
    assign w_stop_sample = (r_state == c_STOP) && baud_tick && w_tick_last;

    // A good stop bit loads when the holding register is free or is being
    // emptied on this very edge; otherwise the new frame is dropped.
    assign w_load      = w_stop_sample && r_rx_s && (!rx_valid || rx_ready);
    assign w_overrun   = w_stop_sample && r_rx_s && rx_valid && !rx_ready;
    assign w_frame_err = w_stop_sample && !r_rx_s;

    assign busy = (r_state != c_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            latch      <= 1'b1;
            stream     <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Strobe and status pulses last exactly one clock.
            latch     <= 1'b1;
            frame_err <= w_frame_err;
            overrun   <= w_overrun;

            // A load on the same edge as an accept takes priority.
            if (w_load) begin
                rx_data  <= par_in;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= c_START;
                        r_tick_cnt <= '0;
                    end
                end

                c_START: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == c_TICK_HALF) begin
                            r_tick_cnt <= '0;
                            if (!r_rx_s) begin
                                r_state   <= c_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                // Line went back high: treat as a glitch.
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end

                c_DATA: begin
                    if (baud_tick) begin
                        if (w_tick_last) begin
                            stream     <= r_rx_s;
                            latch      <= 1'b0;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + c_BIT_W'(1);
                            if (r_bit_cnt == c_BIT_LAST) begin
                                r_state <= c_STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end

                c_STOP: begin
                    if (baud_tick) begin
                        if (w_tick_last) begin
                            r_state    <= c_IDLE;
                            r_tick_cnt <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sequencer
// Purpose  : Self-checking bench for uart_rx_sequencer with an 8-bit shift
//            register model attached and a baud tick every 4 clocks. Stimulus
//            pushes expected bits, words and error pulses into queues; a
//            monitor pops and compares whenever the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sequencer;

    logic       clk;
    logic       reset;
    logic       baud_tick;
    logic       rx;
    logic [7:0] par_in;
    logic       latch;
    logic       stream;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int f_edge  = 0;
    int exp_ferr = 0;
    int exp_ovr  = 0;

    logic       exp_bits[$];
    logic [7:0] exp_data[$];
    logic [7:0] sr = 8'h00;
    logic       mon_pv = 1'b0;
    logic [7:0] mon_pd = 8'h00;

    uart_rx_sequencer #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rx        (rx),
        .par_in    (par_in),
        .latch     (latch),
        .stream    (stream),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Shift register model: shifts right, new bit enters the MSB, so the
    // first bit received ends in bit 0 after eight strobes.
    always @(posedge clk) begin
        if (!latch) sr <= {stream, sr[7:1]};
    end
    assign par_in = sr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = (((cyc + 1) % 4) == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %0h, expected no event", name, act);
    endtask

    // Wait (from a falling edge) until the next rising edge index is 1 mod 4,
    // which fixes the phase of every sample point relative to the frame.
    task automatic align();
        while (((cyc + 1) % 4) != 1) @(negedge clk);
    endtask

    // Drives start bit, nbits data bits (LSB first) and, for a full frame,
    // a stop bit. A low stop bit is shortened so the re-armed start search
    // sees the line high again at its midpoint.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int nbits);
        align();
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            exp_bits.push_back(d[i]);
            repeat (64) @(negedge clk);
        end
        if (nbits == 8) begin
            rx = stop_v;
            repeat (stop_v ? 64 : 48) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (!latch) begin
                    if (exp_bits.size() == 0) unexpected("latch_strobe", {31'd0, stream});
                    else chk("stream_bit", {31'd0, stream}, {31'd0, exp_bits.pop_front()});
                end
                if (rx_valid && (!mon_pv || rx_data != mon_pd)) begin
                    if (exp_data.size() == 0) unexpected("rx_data_load", {24'd0, rx_data});
                    else chk("rx_data_load", {24'd0, rx_data}, {24'd0, exp_data.pop_front()});
                end
                if (frame_err) begin
                    if (exp_ferr == 0) unexpected("frame_err_pulse", 32'd1);
                    else exp_ferr--;
                end
                if (overrun) begin
                    if (exp_ovr == 0) unexpected("overrun_pulse", 32'd1);
                    else exp_ovr--;
                end
            end
            mon_pv = rx_valid;
            mon_pd = rx_data;
        end
    end

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_latch",     {31'd0, latch},     32'd1);
        chk("reset_stream",    {31'd0, stream},    32'd1);
        chk("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        chk("reset_rx_data",   {24'd0, rx_data},   32'd0);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_overrun",   {31'd0, overrun},   32'd0);
        reset = 1'b0;
        repeat (16) @(negedge clk);

        // Frame 0xA5, consumer not ready: word held, then one-clock accept.
        exp_data.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 8);
        repeat (64) @(negedge clk);
        chk("a5_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("a5_data_held",  {24'd0, rx_data},  32'h0000_00A5);
        chk("a5_bits_left",  exp_bits.size(),   32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("a5_valid_after_ack", {31'd0, rx_valid}, 32'd0);

        // Short low glitch: start search aborts, no strobes.
        align();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        chk("glitch_busy_low",  {31'd0, busy},     32'd0);
        chk("glitch_no_valid",  {31'd0, rx_valid}, 32'd0);

        // Frame 0x3C with stop bit low: one frame error, nothing loaded.
        exp_ferr = exp_ferr + 1;
        send_frame(8'h3C, 1'b0, 8);
        repeat (64) @(negedge clk);
        chk("ferr_valid_low",   {31'd0, rx_valid}, 32'd0);
        chk("ferr_pending",     exp_ferr,          32'd0);
        chk("ferr_busy_low",    {31'd0, busy},     32'd0);

        // 0x3C then 0xC3 with no consumer: first kept, second overruns.
        exp_data.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 8);
        repeat (64) @(negedge clk);
        exp_ovr = exp_ovr + 1;
        send_frame(8'hC3, 1'b1, 8);
        repeat (64) @(negedge clk);
        chk("ovr_data_kept",  {24'd0, rx_data},  32'h0000_003C);
        chk("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("ovr_pending",    exp_ovr,           32'd0);

        // 0xC3 again with ready high only on the loading edge: load wins.
        align();
        f_edge = cyc + 1;
        exp_data.push_back(8'hC3);
        fork
            send_frame(8'hC3, 1'b1, 8);
            begin
                while ((cyc + 1) != (f_edge + 607)) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (64) @(negedge clk);
        chk("edge_load_data",  {24'd0, rx_data},  32'h0000_00C3);
        chk("edge_load_valid", {31'd0, rx_valid}, 32'd1);

        // Reset after the third data bit of a partial frame.
        send_frame(8'h5A, 1'b1, 3);
        #2;
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        chk("midrst_latch",    {31'd0, latch},     32'd1);
        chk("midrst_stream",   {31'd0, stream},    32'd1);
        chk("midrst_rx_valid", {31'd0, rx_valid},  32'd0);
        chk("midrst_rx_data",  {24'd0, rx_data},   32'd0);
        chk("midrst_busy",     {31'd0, busy},      32'd0);
        chk("midrst_bits_left", exp_bits.size(),   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);

        exp_data.push_back(8'h55);
        send_frame(8'h55, 1'b1, 8);
        repeat (64) @(negedge clk);
        chk("post_rst_data",  {24'd0, rx_data},  32'h0000_0055);
        chk("post_rst_valid", {31'd0, rx_valid}, 32'd1);

        chk("final_bits_left", exp_bits.size(), 32'd0);
        chk("final_data_left", exp_data.size(), 32'd0);
        chk("final_ferr_left", exp_ferr,        32'd0);
        chk("final_ovr_left",  exp_ovr,         32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
